// File: rtl/loop_seq_pkg.sv
// +--------------------------------------------------------------------+
// | loop_seq_pkg: shared counter-control type and sequencer state enum |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package loop_seq_pkg;

  typedef struct packed {
    logic dval;
    logic inc;
    logic reset;
  } LpCtl;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seqState_e;

endpackage

`default_nettype wire

// File: rtl/loop_seq_counter.sv
// +--------------------------------------------------------------------+
// | LoopCounter: nested loop index counter, level 0 innermost          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module LoopCounter
  import loop_seq_pkg::*;
#(
  parameter int          NDEPTH            = 3,
  parameter int unsigned IDXDW [NDEPTH-1:0] = '{3, 5, 3},
  parameter int          IDXMAXDW          = 11,
  parameter int          STARTPOINT        = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  LpCtl                              i_ctl,
  input  logic [NDEPTH-1:0][IDXMAXDW-1:0]   i_size,
  output logic [NDEPTH-1:0][IDXMAXDW-1:0]   o_idx,
  output logic [NDEPTH-1:0]                 o_loopEnd
);

  logic [NDEPTH-1:0] w_adv;

  for (genvar k = 0; k < NDEPTH; k++) begin : g_level
    localparam int W = int'(IDXDW[k]);
    // Level k moves only when every inner level sits at its last value.
    localparam logic [NDEPTH-1:0] C_INNER_MASK = (NDEPTH'(1) << k) - NDEPTH'(1);

    logic [W-1:0] r_idx;

    assign w_adv[k]     = &(o_loopEnd | ~C_INNER_MASK);
    assign o_idx[k]     = IDXMAXDW'(r_idx);
    assign o_loopEnd[k] = (o_idx[k] == i_size[k]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_idx <= W'(STARTPOINT);
      end else if (i_ctl.dval) begin
        if (i_ctl.reset) begin
          r_idx <= W'(STARTPOINT);
        end else if (i_ctl.inc && w_adv[k]) begin
          r_idx <= o_loopEnd[k] ? W'(STARTPOINT) : r_idx + W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/loop_seq.sv
// +--------------------------------------------------------------------+
// | loop_seq: loop-nest sequencer emitting index tuples with handshake |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module loop_seq
  import loop_seq_pkg::*;
#(
  parameter int          NDEPTH            = 3,
  parameter int unsigned IDXDW [NDEPTH-1:0] = '{3, 5, 3},
  parameter int          IDXMAXDW          = 11,
  parameter int          CNTDW             = 32
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_cfg_valid,
  output logic                              o_cfg_ready,
  input  logic [NDEPTH-1:0][IDXMAXDW-1:0]   i_cfg_size,
  output logic                              o_it_valid,
  input  logic                              i_it_ready,
  output logic [NDEPTH-1:0][IDXMAXDW-1:0]   o_it_idx,
  output logic [NDEPTH-1:0]                 o_it_last,
  input  logic                              i_abort,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [CNTDW-1:0]                  o_beat_cnt
);

  seqState_e                         r_state, w_nextState;
  LpCtl                              w_ctl;
  logic [NDEPTH-1:0][IDXMAXDW-1:0]   r_size;
  logic                              r_done;
  logic [CNTDW-1:0]                  r_beatCnt;
  logic                              w_accept, w_fire, w_finalFire;

  assign w_accept    = o_cfg_ready & i_cfg_valid;
  assign w_fire      = o_it_valid & i_it_ready;
  assign w_finalFire = w_fire & ~i_abort & (&o_it_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_ctl       = '0;
    o_cfg_ready = 1'b0;
    o_it_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cfg_ready = 1'b1;
        if (i_cfg_valid) begin
          w_ctl.reset = 1'b1;
          w_ctl.dval  = 1'b1;
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        o_it_valid = 1'b1;
        // Abort wins over the handshake: the counter is left untouched.
        if (i_abort) begin
          w_nextState = ST_IDLE;
        end else if (w_fire) begin
          w_ctl.inc  = 1'b1;
          w_ctl.dval = 1'b1;
          if (&o_it_last) w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Zero sizes become 1 so the counter always sees a reachable end value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NDEPTH; k++) r_size[k] <= IDXMAXDW'(1);
    end else if (w_accept) begin
      for (int k = 0; k < NDEPTH; k++)
        r_size[k] <= (i_cfg_size[k] == '0) ? IDXMAXDW'(1) : i_cfg_size[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beatCnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_finalFire;
      if (w_accept)    r_beatCnt <= '0;
      else if (w_fire) r_beatCnt <= r_beatCnt + CNTDW'(1);
    end
  end

  LoopCounter #(
    .NDEPTH     (NDEPTH),
    .IDXDW      (IDXDW),
    .IDXMAXDW   (IDXMAXDW),
    .STARTPOINT (1)
  ) u_loopCounter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ctl      (w_ctl),
    .i_size     (r_size),
    .o_idx      (o_it_idx),
    .o_loopEnd  (o_it_last)
  );

  assign o_busy     = (r_state == ST_RUN);
  assign o_done     = r_done;
  assign o_beat_cnt = r_beatCnt;

endmodule

`default_nettype wire

// File: tb/tb_loop_seq.sv
// +--------------------------------------------------------------------+
// | tb_loop_seq: directed scoreboard bench for the loop-nest sequencer |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_loop_seq;

  logic                  clk = 1'b0;
  logic                  rstN;
  logic                  cfgValid, cfgReady;
  logic [2:0][10:0]      cfgSize;
  logic                  itValid, itReady;
  logic [2:0][10:0]      itIdx;
  logic [2:0]            itLast;
  logic                  abortIn, busy, done;
  logic [31:0]           beatCnt;

  typedef struct packed {
    logic [2:0][10:0] idx;
    logic [2:0]       last;
  } beat_t;

  beat_t expQ[$];
  int    nAssert = 0;
  int    nFail   = 0;
  int    beats;

  always #5 clk = ~clk;

  loop_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_cfg_valid (cfgValid),
    .o_cfg_ready (cfgReady),
    .i_cfg_size  (cfgSize),
    .o_it_valid  (itValid),
    .i_it_ready  (itReady),
    .o_it_idx    (itIdx),
    .o_it_last   (itLast),
    .i_abort     (abortIn),
    .o_busy      (busy),
    .o_done      (done),
    .o_beat_cnt  (beatCnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushRun(input int s0, input int s1, input int s2);
    int m0, m1, m2;
    beat_t b;
    m0 = (s0 == 0) ? 1 : s0;
    m1 = (s1 == 0) ? 1 : s1;
    m2 = (s2 == 0) ? 1 : s2;
    for (int c = 1; c <= m2; c++)
      for (int bb = 1; bb <= m1; bb++)
        for (int a = 1; a <= m0; a++) begin
          b.idx  = {11'(c), 11'(bb), 11'(a)};
          b.last = {c == m2, bb == m1, a == m0};
          expQ.push_back(b);
        end
  endtask

  task automatic checkResetVals(input string tag);
    chk({tag, "_cfgReady"}, 64'(cfgReady), 64'd1);
    chk({tag, "_itValid"},  64'(itValid),  64'd0);
    chk({tag, "_busy"},     64'(busy),     64'd0);
    chk({tag, "_done"},     64'(done),     64'd0);
    chk({tag, "_beatCnt"},  64'(beatCnt),  64'd0);
    chk({tag, "_idx"},      64'(itIdx),    64'({11'd1, 11'd1, 11'd1}));
    chk({tag, "_last"},     64'(itLast),   64'(3'b111));
  endtask

  task automatic sendCfg(input string tag, input int s0, input int s1, input int s2);
    chk({tag, "_cfgReady"}, 64'(cfgReady), 64'd1);
    cfgValid = 1'b1;
    cfgSize  = {11'(s2), 11'(s1), 11'(s0)};
    pushRun(s0, s1, s2);
    tick();
    cfgValid = 1'b0;
    cfgSize  = {11'd7, 11'd7, 11'd7};
  endtask

  // readyMode 0: always ready; 1: ready pattern 1,0,0 repeating.
  // abortAt: beat number (1-based) on which abort is raised with ready=1; 0 = none.
  task automatic drainRun(input string tag, input int readyMode, input int abortAt,
                          output int nBeats);
    int cyc;
    bit aborted;
    beat_t obs;
    nBeats  = 0;
    aborted = 1'b0;
    cyc     = 0;
    while (expQ.size() != 0 && cyc < 300) begin
      obs = {itIdx, itLast};
      chk({tag, "_valid"}, 64'(itValid), 64'd1);
      chk({tag, "_busy"},  64'(busy),    64'd1);
      chk({tag, "_noDone"}, 64'(done),   64'd0);
      chk({tag, "_beat"},  64'(obs),     64'(expQ[0]));
      itReady = (readyMode == 0) ? 1'b1 : ((cyc % 3) == 0);
      abortIn = itReady && (abortAt != 0) && (nBeats + 1 == abortAt);
      if (itReady) begin
        void'(expQ.pop_front());
        nBeats++;
      end
      if (abortIn) begin
        aborted = 1'b1;
        expQ.delete();
      end
      tick();
      cyc++;
    end
    if (cyc >= 300) chk({tag, "_timeout"}, 64'd1, 64'd0);
    abortIn = 1'b0;
    itReady = 1'b0;
    chk({tag, "_endDone"},    64'(done),     aborted ? 64'd0 : 64'd1);
    chk({tag, "_endReady"},   64'(cfgReady), 64'd1);
    chk({tag, "_endValid"},   64'(itValid),  64'd0);
    chk({tag, "_endBusy"},    64'(busy),     64'd0);
    chk({tag, "_endBeatCnt"}, 64'(beatCnt),  64'(nBeats));
  endtask

  initial begin
    rstN     = 1'b0;
    cfgValid = 1'b0;
    cfgSize  = '0;
    itReady  = 1'b0;
    abortIn  = 1'b0;
    tick();
    tick();
    checkResetVals("rst");
    rstN = 1'b1;
    tick();
    checkResetVals("postRst");

    // Abort in IDLE must be ignored.
    abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    chk("idleAbort_ready", 64'(cfgReady), 64'd1);

    // Sizes {2,3,1}, ready always high.
    sendCfg("s231", 2, 3, 1);
    drainRun("s231", 0, 0, beats);
    chk("s231_beats", 64'(beats), 64'd6);
    tick();
    chk("s231_donePulse", 64'(done), 64'd0);

    // Same config under backpressure.
    sendCfg("bp", 2, 3, 1);
    drainRun("bp", 1, 0, beats);
    chk("bp_beats", 64'(beats), 64'd6);
    tick();

    // All-zero sizes collapse to a single beat.
    sendCfg("zero", 0, 0, 0);
    drainRun("zero", 0, 0, beats);
    chk("zero_beats", 64'(beats), 64'd1);
    tick();

    // Abort on the third beat of {4,2,2}.
    sendCfg("abort", 4, 2, 2);
    drainRun("abort", 0, 3, beats);
    chk("abort_beats", 64'(beats), 64'd3);
    tick();
    chk("abort_noLateDone", 64'(done), 64'd0);
    sendCfg("postAbort", 2, 3, 1);
    drainRun("postAbort", 0, 0, beats);

    // Back-to-back: new config offered in the done cycle.
    sendCfg("b2b", 3, 1, 1);
    drainRun("b2bA", 0, 0, beats);
    chk("b2bA_beats", 64'(beats), 64'd3);
    sendCfg("b2bSecond", 1, 2, 2);
    drainRun("b2bB", 0, 0, beats);
    chk("b2bB_beats", 64'(beats), 64'd4);
    tick();

    // Reset mid-run after four beats of {3,3,3}.
    sendCfg("midRst", 3, 3, 3);
    for (int i = 0; i < 4; i++) begin
      chk("midRst_beat", 64'({itIdx, itLast}), 64'(expQ.pop_front()));
      itReady = 1'b1;
      tick();
    end
    chk("midRst_cnt4", 64'(beatCnt), 64'd4);
    rstN = 1'b0;
    #2;
    checkResetVals("midRstLow");
    tick();
    rstN = 1'b1;
    itReady = 1'b0;
    expQ.delete();
    tick();
    checkResetVals("midRstAfter");
    tick();
    chk("midRst_noDone", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

`default_nettype wire
